// File: rtl/dp_ram_dma.sv
// rtl/dp_ram_dma.sv - J1 data RAM port-A block copy / fill engine
// Copies or fills a word block through RAM port A under start/abort control.
module dp_ram_dma #(
  parameter int adr_width = 13,
  parameter int dat_width = 16
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 start,
  input  logic                 mode,
  input  logic [adr_width-1:0] src_adr,
  input  logic [adr_width-1:0] dst_adr,
  input  logic [adr_width:0]   len,
  input  logic [dat_width-1:0] fill_dat,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [adr_width:0]   remain,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [adr_width-1:0] ram_adr,
  output logic [dat_width-1:0] ram_dat_w,
  input  logic [dat_width-1:0] ram_dat_r
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  localparam logic [adr_width-1:0] adr_one = 1;
  localparam logic [adr_width:0]   cnt_one = 1;

  state_t               state_q, state_d;
  logic [adr_width-1:0] src_q, src_d;
  logic [adr_width-1:0] dst_q, dst_d;
  logic [adr_width-1:0] off_q, off_d;
  logic [dat_width-1:0] fill_q, fill_d;
  logic [adr_width:0]   remain_q, remain_d;
  logic                 last_word;

  assign last_word = (remain_q == cnt_one);
  assign remain    = remain_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    off_d    = off_q;
    fill_d   = fill_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d    = src_adr;
          dst_d    = dst_adr;
          fill_d   = fill_dat;
          remain_d = len;
          off_d    = '0;
          if (len == '0)  state_d = DONE;
          else if (mode)  state_d = FILL;
          else            state_d = RD;
        end
      end
      RD: begin
        state_d = abort ? IDLE : WR;
      end
      WR, FILL: begin
        // The write presented this cycle lands even when aborted, so it is counted.
        off_d    = off_q + adr_one;
        remain_d = remain_q - cnt_one;
        if (abort)          state_d = IDLE;
        else if (last_word) state_d = DONE;
        else                state_d = (state_q == WR) ? RD : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      off_q    <= '0;
      fill_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      off_q    <= off_d;
      fill_q   <= fill_d;
      remain_q <= remain_d;
    end
  end

  // Port A is decoded from registered state; write data in WR is the RAM's own registered read.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = '0;
    ram_dat_w = '0;
    case (state_q)
      RD: begin
        busy    = 1'b1;
        ram_en  = 1'b1;
        ram_adr = src_q + off_q;
      end
      WR: begin
        busy      = 1'b1;
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_adr   = dst_q + off_q;
        ram_dat_w = ram_dat_r;
      end
      FILL: begin
        busy      = 1'b1;
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_adr   = dst_q + off_q;
        ram_dat_w = fill_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
